// File: rtl/user_dma_mm2s_cmd_ctrl_if.sv
// AXI4 read-address and read-data channel bundle for the MM2S command controller.
// The master modport is the DMA side; the slave modport is the memory side.
interface user_dma_mm2s_cmd_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RLAST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/user_dma_mm2s_cmd_ctrl.sv
// MM2S command controller: splits one descriptor into 4 KB-safe AXI4 INCR read bursts
// and forwards the returned beats to the stream FIFO, one burst outstanding at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; descriptor latched when start is seen
//   CALC   | size the next burst against remaining, max burst and 4 KB page
//   ADDR   | ARVALID held with stable ARADDR/ARLEN until ARREADY
//   DATA   | accepting R beats of the current burst, throttled by the FIFO
//   DONE   | transfer finished; done pulses in the following cycle
module user_dma_mm2s_cmd_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr,
    input  logic [23:0]                   xfer_words,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [23:0]                   MM_count,
    output logic [C_M_AXI_DATA_WIDTH-1:0] MM_data,
    output logic                          rnext,
    input  logic                          fifo_mm2s_almost_full,
    user_dma_mm2s_cmd_ctrl_if.master      m_axi
);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [7:0]    beat_cnt;
    logic [23:0]   remaining;
    logic [23:0]   mm_count_q;
    logic          done_q;
    logic          error_q;

    logic [12:0]   page_room;
    logic [23:0]   page_words;
    logic [23:0]   len_c;
    logic [23:0]   burst_words;
    logic          last_beat;
    logic          rready_c;
    logic          beat;

    // Largest burst that fits the remaining words, the burst cap and the rest of the 4 KB page
    always_comb begin
        page_room  = 13'd4096 - {1'b0, addr[11:0]};
        page_words = {11'd0, page_room} >> LOG2B;
        len_c      = remaining;
        if (len_c > 24'(C_MAX_BURST_LEN)) len_c = 24'(C_MAX_BURST_LEN);
        if (len_c > page_words)           len_c = page_words;
    end

    assign burst_words = {16'd0, arlen} + 24'd1;
    assign last_beat   = (beat_cnt == arlen);
    assign rready_c    = (state == S_DATA) && !fifo_mm2s_almost_full;
    assign beat        = m_axi.M_AXI_RVALID && rready_c;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state      <= S_IDLE;
            addr       <= '0;
            araddr     <= '0;
            arlen      <= '0;
            beat_cnt   <= '0;
            remaining  <= '0;
            mm_count_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= src_addr & ~AW'(BYTES - 1);
                        remaining  <= xfer_words;
                        mm_count_q <= xfer_words;
                        error_q    <= 1'b0;
                        state      <= (xfer_words == 24'd0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    araddr   <= addr;
                    arlen    <= 8'(len_c - 24'd1);
                    beat_cnt <= '0;
                    state    <= S_ADDR;
                end
                S_ADDR: begin
                    if (m_axi.M_AXI_ARREADY) state <= S_DATA;
                end
                S_DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // Both faults are recorded but the burst is still drained to keep AXI in step
                        if (m_axi.M_AXI_RRESP != 2'b00 || m_axi.M_AXI_RLAST != last_beat)
                            error_q <= 1'b1;
                        if (last_beat) begin
                            addr      <= addr + (AW'(burst_words) << LOG2B);
                            remaining <= remaining - burst_words;
                            state     <= (remaining == burst_words) ? S_DONE : S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign MM_count = mm_count_q;
    assign MM_data  = m_axi.M_AXI_RDATA;
    assign rnext    = beat;

    assign m_axi.M_AXI_ARADDR  = araddr;
    assign m_axi.M_AXI_ARLEN   = arlen;
    assign m_axi.M_AXI_ARSIZE  = 3'(LOG2B);
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARVALID = (state == S_ADDR);
    assign m_axi.M_AXI_RREADY  = rready_c;
endmodule

// File: tb/tb_user_dma_mm2s_cmd_ctrl.sv
// Directed bench for the MM2S command controller with a behavioural AXI read slave.
// The slave returns RDATA equal to the beat's byte address, so data order proves addressing.
module tb_user_dma_mm2s_cmd_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [23:0] xfer_words = '0;
    logic        busy, done, error, rnext;
    logic        af = 1'b0;
    logic [23:0] mm_count;
    logic [31:0] mm_data;

    user_dma_mm2s_cmd_ctrl_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    user_dma_mm2s_cmd_ctrl #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_MAX_BURST_LEN(16)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .start(start),
        .src_addr(src_addr),
        .xfer_words(xfer_words),
        .busy(busy),
        .done(done),
        .error(error),
        .MM_count(mm_count),
        .MM_data(mm_data),
        .rnext(rnext),
        .fifo_mm2s_almost_full(af),
        .m_axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // slave knobs
    int ar_delay = 0;
    bit af_toggle = 1'b0;
    int err_beat = -1;
    int rlast_burst = -1;

    // slave / monitor state
    bit          have_burst = 1'b0;
    logic [31:0] b_addr = '0;
    int          b_len = 0, b_beat = 0, burst_idx = 0, gbeat = 0, ar_cycles = 0;
    bit          hold_valid = 1'b0;
    logic [31:0] held_addr = '0;
    logic [7:0]  held_len = '0;
    bit          exp_rr;
    logic [31:0] q_addr[$];
    int          q_len[$];
    logic [31:0] q_data[$];
    int busy_cycles = 0, done_count = 0, last_done_cyc = 0, last_beat_cyc = 0;
    int start_cyc = 0, first_ar_cyc = -1;

    initial begin
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = 2'b00;
        axi.M_AXI_RLAST   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            axi.M_AXI_ARREADY = (ar_cycles >= ar_delay);
            af = af_toggle ? (((cyc / 3) % 2) == 1) : 1'b0;
            if (have_burst) begin
                axi.M_AXI_RVALID = 1'b1;
                axi.M_AXI_RDATA  = b_addr + 32'(b_beat * 4);
                axi.M_AXI_RRESP  = (gbeat == err_beat) ? 2'b10 : 2'b00;
                axi.M_AXI_RLAST  = (burst_idx == rlast_burst) ? (b_beat == b_len - 1) : (b_beat == b_len);
            end else begin
                axi.M_AXI_RVALID = 1'b0;
                axi.M_AXI_RDATA  = 32'hDEAD_BEEF;
                axi.M_AXI_RRESP  = 2'b00;
                axi.M_AXI_RLAST  = 1'b0;
            end
            #1;
            if (rst) begin
                have_burst = 1'b0;
                hold_valid = 1'b0;
                ar_cycles  = 0;
            end else begin
                exp_rr = have_burst && !af;
                checks++;
                if (axi.M_AXI_RREADY !== exp_rr) begin
                    failures++;
                    $display("FAIL rready cyc=%0d: got %b expected %b", cyc, axi.M_AXI_RREADY, exp_rr);
                end
                checks++;
                if (rnext !== (axi.M_AXI_RVALID && exp_rr) || mm_data !== axi.M_AXI_RDATA) begin
                    failures++;
                    $display("FAIL rnext_data cyc=%0d: rnext %b data %h expected rnext %b data %h",
                             cyc, rnext, mm_data, axi.M_AXI_RVALID && exp_rr, axi.M_AXI_RDATA);
                end
                if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
                    q_data.push_back(axi.M_AXI_RDATA);
                    gbeat++;
                    last_beat_cyc = cyc;
                    b_beat++;
                    if (b_beat > b_len) begin
                        have_burst = 1'b0;
                        burst_idx++;
                    end
                end
                if (axi.M_AXI_ARVALID) begin
                    if (first_ar_cyc < 0) first_ar_cyc = cyc;
                    if (hold_valid) begin
                        checks++;
                        if (axi.M_AXI_ARADDR !== held_addr || axi.M_AXI_ARLEN !== held_len) begin
                            failures++;
                            $display("FAIL ar_stable cyc=%0d: got %h/%0d expected %h/%0d",
                                     cyc, axi.M_AXI_ARADDR, axi.M_AXI_ARLEN, held_addr, held_len);
                        end
                    end
                    if (axi.M_AXI_ARREADY) begin
                        q_addr.push_back(axi.M_AXI_ARADDR);
                        q_len.push_back(int'(axi.M_AXI_ARLEN));
                        have_burst = 1'b1;
                        b_addr = axi.M_AXI_ARADDR;
                        b_len = int'(axi.M_AXI_ARLEN);
                        b_beat = 0;
                        hold_valid = 1'b0;
                        ar_cycles = 0;
                    end else begin
                        hold_valid = 1'b1;
                        held_addr = axi.M_AXI_ARADDR;
                        held_len = axi.M_AXI_ARLEN;
                        ar_cycles++;
                    end
                end else begin
                    hold_valid = 1'b0;
                end
                if (busy) busy_cycles++;
                if (done) begin
                    done_count++;
                    last_done_cyc = cyc;
                    checks++;
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL busy_in_done cyc=%0d: got %b expected 0", cyc, busy);
                    end
                end
                if (start && !busy) start_cyc = cyc;
            end
        end
    end

    task automatic run_xfer(input logic [31:0] a, input logic [23:0] w, input int extra_at,
                            output bit timeout);
        q_addr.delete();
        q_len.delete();
        q_data.delete();
        busy_cycles = 0;
        done_count = 0;
        burst_idx = 0;
        gbeat = 0;
        first_ar_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        src_addr = a;
        xfer_words = w;
        @(negedge clk);
        start = 1'b0;
        src_addr = ~a;
        xfer_words = w + 24'd5;
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done_count > 0) begin
                timeout = 1'b0;
                break;
            end
            start = (i == extra_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        checks++;
        if ({busy, done, error, rnext, axi.M_AXI_ARVALID, axi.M_AXI_RREADY} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, error, rnext, axi.M_AXI_ARVALID, axi.M_AXI_RREADY});
        end
        checks++;
        if (mm_count !== 24'd0 || axi.M_AXI_ARADDR !== 32'd0 || axi.M_AXI_ARLEN !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs: got count %0d araddr %h arlen %0d expected 0 0 0",
                     mm_count, axi.M_AXI_ARADDR, axi.M_AXI_ARLEN);
        end
    endtask

    task automatic test_basic();
        bit to;
        int bad;
        logic [31:0] ea[3];
        int el[3];
        ea = '{32'h1000, 32'h1040, 32'h1080};
        el = '{15, 15, 7};
        run_xfer(32'h1000, 24'd40, -1, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++;
        if (q_addr.size() != 3) begin
            failures++;
            $display("FAIL basic_bursts: got %0d bursts expected 3", q_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_addr[i] !== ea[i] || q_len[i] != el[i]) begin
                    failures++;
                    $display("FAIL basic_burst%0d: got %h/%0d expected %h/%0d", i, q_addr[i], q_len[i], ea[i], el[i]);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== 32'h1000 + 32'(i * 4)) bad++;
        checks++;
        if (q_data.size() != 40 || bad != 0) begin
            failures++;
            $display("FAIL basic_beats: got %0d beats %0d bad expected 40 beats 0 bad", q_data.size(), bad);
        end
        checks++;
        if (first_ar_cyc - start_cyc != 2) begin
            failures++;
            $display("FAIL basic_ar_latency: got %0d expected 2", first_ar_cyc - start_cyc);
        end
        checks++;
        if (last_done_cyc - last_beat_cyc != 2 || done_count != 1) begin
            failures++;
            $display("FAIL basic_done_timing: got offset %0d count %0d expected 2 1",
                     last_done_cyc - last_beat_cyc, done_count);
        end
        checks++;
        if (mm_count !== 24'd40 || error !== 1'b0 || axi.M_AXI_ARSIZE !== 3'd2 || axi.M_AXI_ARBURST !== 2'b01) begin
            failures++;
            $display("FAIL basic_status: got count %0d err %b size %0d burst %0d expected 40 0 2 1",
                     mm_count, error, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST);
        end
    endtask

    task automatic test_boundary();
        bit to;
        run_xfer(32'h0000_0FF8, 24'd8, -1, to);
        checks++;
        if (to || q_addr.size() != 2) begin
            failures++;
            $display("FAIL boundary_bursts: got %0d bursts timeout %b expected 2 0", q_addr.size(), to);
        end else begin
            checks++;
            if (q_addr[0] !== 32'h0FF8 || q_len[0] != 1 || q_addr[1] !== 32'h1000 || q_len[1] != 5) begin
                failures++;
                $display("FAIL boundary_split: got %h/%0d %h/%0d expected 0ff8/1 1000/5",
                         q_addr[0], q_len[0], q_addr[1], q_len[1]);
            end
        end
        // ARADDR wraps past the top of the address space
        run_xfer(32'hFFFF_FFF0, 24'd8, -1, to);
        checks++;
        if (to || q_addr.size() != 2) begin
            failures++;
            $display("FAIL wrap_bursts: got %0d bursts timeout %b expected 2 0", q_addr.size(), to);
        end else begin
            checks++;
            if (q_addr[0] !== 32'hFFFF_FFF0 || q_len[0] != 3 || q_addr[1] !== 32'h0 || q_len[1] != 3) begin
                failures++;
                $display("FAIL wrap_split: got %h/%0d %h/%0d expected fffffff0/3 0/3",
                         q_addr[0], q_len[0], q_addr[1], q_len[1]);
            end
        end
    endtask

    task automatic test_zero_words();
        bit to;
        run_xfer(32'h2000, 24'd0, -1, to);
        checks++;
        if (to || q_addr.size() != 0 || first_ar_cyc != -1) begin
            failures++;
            $display("FAIL zero_no_ar: got %0d bursts timeout %b expected 0 0", q_addr.size(), to);
        end
        checks++;
        if (last_done_cyc - start_cyc != 2 || busy_cycles != 1) begin
            failures++;
            $display("FAIL zero_timing: got done offset %0d busy %0d expected 2 1",
                     last_done_cyc - start_cyc, busy_cycles);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        af_toggle = 1'b1;
        ar_delay = 5;
        run_xfer(32'h2000, 24'd20, -1, to);
        af_toggle = 1'b0;
        ar_delay = 0;
        checks++;
        if (to || q_addr.size() != 2) begin
            failures++;
            $display("FAIL bp_bursts: got %0d bursts timeout %b expected 2 0", q_addr.size(), to);
        end else begin
            checks++;
            if (q_addr[0] !== 32'h2000 || q_len[0] != 15 || q_addr[1] !== 32'h2040 || q_len[1] != 3) begin
                failures++;
                $display("FAIL bp_split: got %h/%0d %h/%0d expected 2000/15 2040/3",
                         q_addr[0], q_len[0], q_addr[1], q_len[1]);
            end
        end
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== 32'h2000 + 32'(i * 4)) bad++;
        checks++;
        if (q_data.size() != 20 || bad != 0 || error !== 1'b0) begin
            failures++;
            $display("FAIL bp_beats: got %0d beats %0d bad err %b expected 20 0 0", q_data.size(), bad, error);
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        run_xfer(32'h1000, 24'd40, 6, to);
        checks++;
        if (to || q_addr.size() != 3 || q_data.size() != 40 || mm_count !== 24'd40) begin
            failures++;
            $display("FAIL busy_start: got %0d bursts %0d beats count %0d expected 3 40 40",
                     q_addr.size(), q_data.size(), mm_count);
        end else begin
            checks++;
            if (q_addr[1] !== 32'h1040 || q_addr[2] !== 32'h1080) begin
                failures++;
                $display("FAIL busy_start_addr: got %h %h expected 1040 1080", q_addr[1], q_addr[2]);
            end
        end
    endtask

    task automatic test_errors();
        bit to;
        err_beat = 3;
        rlast_burst = 1;
        run_xfer(32'h3000, 24'd40, -1, to);
        err_beat = -1;
        rlast_burst = -1;
        checks++;
        if (to || q_data.size() != 40 || error !== 1'b1) begin
            failures++;
            $display("FAIL err_both: got timeout %b beats %0d err %b expected 0 40 1", to, q_data.size(), error);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b expected 1", error);
        end
        run_xfer(32'h6000, 24'd3, -1, to);
        checks++;
        if (to || error !== 1'b0 || q_len.size() != 1) begin
            failures++;
            $display("FAIL err_cleared: got timeout %b err %b bursts %0d expected 0 0 1", to, error, q_len.size());
        end
        rlast_burst = 1;
        run_xfer(32'h3000, 24'd40, -1, to);
        rlast_burst = -1;
        checks++;
        if (to || error !== 1'b1 || done_count != 1) begin
            failures++;
            $display("FAIL err_rlast: got timeout %b err %b done %0d expected 0 1 1", to, error, done_count);
        end
        err_beat = 17;
        run_xfer(32'h3000, 24'd40, -1, to);
        err_beat = -1;
        checks++;
        if (to || error !== 1'b1) begin
            failures++;
            $display("FAIL err_rresp: got timeout %b err %b expected 0 1", to, error);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        q_addr.delete();
        q_data.delete();
        gbeat = 0;
        @(negedge clk);
        start = 1'b1;
        src_addr = 32'h4000;
        xfer_words = 24'd40;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 500 && gbeat < 5; i++) @(negedge clk);
        checks++;
        if (gbeat < 5) begin
            failures++;
            $display("FAIL mid_reach_data: got %0d beats expected >=5", gbeat);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({busy, done, error, rnext, axi.M_AXI_ARVALID, axi.M_AXI_RREADY} !== 6'b0 ||
            mm_count !== 24'd0 || axi.M_AXI_ARADDR !== 32'd0 || axi.M_AXI_ARLEN !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got ctrl %b count %0d araddr %h arlen %0d expected all 0",
                     {busy, done, error, rnext, axi.M_AXI_ARVALID, axi.M_AXI_RREADY},
                     mm_count, axi.M_AXI_ARADDR, axi.M_AXI_ARLEN);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_xfer(32'h5000, 24'd4, -1, to);
        checks++;
        if (to || q_addr.size() != 1 || q_data.size() != 4 || error !== 1'b0 || mm_count !== 24'd4) begin
            failures++;
            $display("FAIL mid_fresh_run: got timeout %b bursts %0d beats %0d err %b count %0d expected 0 1 4 0 4",
                     to, q_addr.size(), q_data.size(), error, mm_count);
        end else begin
            checks++;
            if (q_addr[0] !== 32'h5000 || q_len[0] != 3 || q_data[3] !== 32'h500C) begin
                failures++;
                $display("FAIL mid_fresh_burst: got %h/%0d last %h expected 5000/3 500c",
                         q_addr[0], q_len[0], q_data[3]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_basic();
        test_boundary();
        test_zero_words();
        test_backpressure();
        test_start_while_busy();
        test_errors();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
